// File: rtl/usb4_lane_pkg.sv
// rtl/usb4_lane_pkg.sv - shared constants and helpers for the lane distributer
package usb4_lane_pkg;

    // Mode encoding for mode_q / lane_mode
    localparam logic MODE_ALL_LANES   = 1'b0;
    localparam logic MODE_SINGLE_LANE = 1'b1;

    // Width of a lane index; at least one bit so a single-lane build still has a counter
    function automatic int lane_idx_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_word_serializer.sv
// rtl/lane_word_serializer.sv - re-serialises aligned lane words into a byte stream
module lane_word_serializer
    import usb4_lane_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_LANES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_enable_i,
    input  logic                        single_lane_i,
    input  logic [NUM_LANES*DATA_W-1:0] rx_lanes_i,
    input  logic                        rx_lanes_valid_i,
    output logic                        rx_lanes_ready_o,
    output logic [DATA_W-1:0]           rx_data_out_o,
    output logic                        rx_out_valid_o,
    input  logic                        rx_out_ready_i
);

    localparam int IDX_W  = lane_idx_w(NUM_LANES);
    localparam int WORD_W = NUM_LANES * DATA_W;
    localparam logic [IDX_W-1:0] LAST_ALL = IDX_W'(NUM_LANES - 1);

    logic              full_q, full_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  last_idx;
    logic              capture;

    assign last_idx = single_lane_i ? '0 : LAST_ALL;

    // Accept a new word when empty, or when the last byte leaves this very cycle
    assign rx_lanes_ready_o = rx_enable_i && (!full_q || ((idx_q == last_idx) && rx_out_ready_i));
    assign capture          = rx_lanes_valid_i && rx_lanes_ready_o;
    assign rx_out_valid_o   = full_q;

    // Present the buffered lane selected by the byte index
    always_comb begin
        rx_data_out_o = '0;
        if (full_q) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    rx_data_out_o = buf_q[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Buffer fill/drain: capture wins over drain since it only happens on the last byte
    always_comb begin
        full_d = full_q;
        idx_d  = idx_q;
        buf_d  = buf_q;
        if (!rx_enable_i) begin
            full_d = 1'b0;
            idx_d  = '0;
            buf_d  = '0;
        end else if (capture) begin
            full_d = 1'b1;
            idx_d  = '0;
            buf_d  = rx_lanes_i;
        end else if (full_q && rx_out_ready_i) begin
            if (idx_q == last_idx) begin
                full_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            idx_q  <= '0;
            buf_q  <= '0;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/multi_lane_distributer.sv
// rtl/multi_lane_distributer.sv - round-robin byte striping across lanes plus RX re-serialisation
module multi_lane_distributer
    import usb4_lane_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_LANES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_enable,
    input  logic                        rx_enable,
    input  logic                        lane_mode,
    input  logic [DATA_W-1:0]           tx_data_in,
    input  logic                        tx_in_valid,
    output logic                        tx_in_ready,
    output logic [NUM_LANES*DATA_W-1:0] tx_lanes,
    output logic                        tx_lanes_valid,
    input  logic [NUM_LANES*DATA_W-1:0] rx_lanes,
    input  logic                        rx_lanes_valid,
    output logic                        rx_lanes_ready,
    output logic [DATA_W-1:0]           rx_data_out,
    output logic                        rx_out_valid,
    input  logic                        rx_out_ready,
    output logic                        mode_q
);

    localparam int IDX_W  = lane_idx_w(NUM_LANES);
    localparam int WORD_W = NUM_LANES * DATA_W;
    localparam logic [IDX_W-1:0] LAST_ALL = IDX_W'(NUM_LANES - 1);

    logic              mode_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0] tx_lanes_q, tx_lanes_d;
    logic              tx_valid_q, tx_valid_d;
    logic [IDX_W-1:0]  last_idx;
    logic              single_lane;
    logic              tx_accept;

    assign tx_in_ready    = tx_enable;
    assign tx_accept      = tx_in_valid && tx_in_ready;
    assign single_lane    = (mode_q == MODE_SINGLE_LANE);
    assign last_idx       = single_lane ? '0 : LAST_ALL;
    assign tx_lanes       = tx_lanes_q;
    assign tx_lanes_valid = tx_valid_q;

    // Mode only reloads while both directions are idle, so it cannot change mid-stripe
    always_comb begin
        mode_d = mode_q;
        if (!tx_enable && !rx_enable) begin
            mode_d = lane_mode;
        end
    end

    // TX striping: fill shadow slots, publish the word when the last active slot is written
    always_comb begin
        shadow_d   = shadow_q;
        tx_idx_d   = tx_idx_q;
        tx_lanes_d = tx_lanes_q;
        tx_valid_d = 1'b0;
        if (!tx_enable) begin
            shadow_d   = '0;
            tx_idx_d   = '0;
            tx_lanes_d = '0;
        end else if (tx_accept) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (tx_idx_q == IDX_W'(k)) begin
                    shadow_d[k*DATA_W +: DATA_W] = tx_data_in;
                end
            end
            if (tx_idx_q == last_idx) begin
                tx_idx_d   = '0;
                tx_valid_d = 1'b1;
                if (single_lane) begin
                    tx_lanes_d                = '0;
                    tx_lanes_d[DATA_W-1:0]    = shadow_d[DATA_W-1:0];
                end else begin
                    tx_lanes_d = shadow_d;
                end
            end else begin
                tx_idx_d = tx_idx_q + 1'b1;
            end
        end
    end

    // State registers for mode and TX striping
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_ALL_LANES;
            tx_idx_q   <= '0;
            shadow_q   <= '0;
            tx_lanes_q <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            tx_idx_q   <= tx_idx_d;
            shadow_q   <= shadow_d;
            tx_lanes_q <= tx_lanes_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    lane_word_serializer #(
        .DATA_W    (DATA_W),
        .NUM_LANES (NUM_LANES)
    ) u_rx_ser (
        .clk              (clk),
        .rst              (rst),
        .rx_enable_i      (rx_enable),
        .single_lane_i    (single_lane),
        .rx_lanes_i       (rx_lanes),
        .rx_lanes_valid_i (rx_lanes_valid),
        .rx_lanes_ready_o (rx_lanes_ready),
        .rx_data_out_o    (rx_data_out),
        .rx_out_valid_o   (rx_out_valid),
        .rx_out_ready_i   (rx_out_ready)
    );

endmodule

// File: doc/multi_lane_distributer.md
# multi_lane_distributer

Parametrised lane distributer for the logical layer, sitting between the byte-wide data bus and the per-lane encoder/decoder stage. On transmit it stripes a byte stream round-robin across `NUM_LANES` lanes and presents one aligned lane word per completed stripe. On receive it takes aligned lane words and re-serialises them into a byte stream in lane order, with backpressure on both sides. A runtime mode selects full-width or single-lane operation.

## Interface
- `DATA_W`, 8: symbol width per lane, in bits.
- `NUM_LANES`, 2: number of physical lanes; must be ≥1.
- `clk`  in  1  the only clock for the block.
- `rst`  in  1  reset: synchronous, active-high.
- `tx_enable`  in  1  transmit-side enable; low clears TX state.
- `rx_enable`  in  1  receive-side enable; low clears RX state.
- `lane_mode`  in  1  0 = all lanes active, 1 = lane 0 only; sampled only while idle.
- `tx_data_in`  in  DATA_W  byte from the data bus.
- `tx_in_valid`  in  1  `tx_data_in` is valid.
- `tx_in_ready`  out  1  equals `tx_enable`.
- `tx_lanes`  out  NUM_LANES*DATA_W  lane word; lane k occupies bits [k*DATA_W +: DATA_W].
- `tx_lanes_valid`  out  1  one-cycle strobe: `tx_lanes` is new.
- `rx_lanes`  in  NUM_LANES*DATA_W  lane word from the decoders.
- `rx_lanes_valid`  in  1  `rx_lanes` is valid.
- `rx_lanes_ready`  out  1  block accepts `rx_lanes` this cycle.
- `rx_data_out`  out  DATA_W  byte to the data bus.
- `rx_out_valid`  out  1  `rx_data_out` is valid.
- `rx_out_ready`  in  1  the consumer accepts `rx_data_out`.
- `mode_q`  out  1  the mode currently in effect.

## Operation
- **Active lane count.** L = NUM_LANES when `mode_q`=0, and L = 1 when `mode_q`=1.
- **Mode register.** `mode_q` loads `lane_mode` on any edge where `tx_enable`=0 and `rx_enable`=0. Otherwise it holds, so the mode never changes mid-stripe.
- **TX accept.** An accept is `tx_in_valid && tx_in_ready`. Each accept writes the byte into shadow slot `tx_idx`.
  - If `tx_idx`=L-1: the shadow word, including the current byte, is copied to `tx_lanes`; inactive lanes are driven to 0; `tx_lanes_valid`=1 for the next cycle; `tx_idx` returns to 0.
  - Otherwise `tx_idx` increments.
- **TX hold.** `tx_lanes` holds its value between strobes.
- **TX without a valid byte.** `tx_idx` holds and no strobe is generated.
- **TX disable.** `tx_enable`=0 discards a partial stripe and clears `tx_idx`, the shadow register, `tx_lanes` and `tx_lanes_valid`.
- **RX capture.** A capture is `rx_lanes_valid && rx_lanes_ready`. It loads a word buffer with the lane word, sets `rx_idx`=0 and marks the buffer full.
- **RX output.** While the buffer is full, `rx_out_valid`=1 and `rx_data_out` = buffer lane `rx_idx`.
  - On `rx_out_ready`: if `rx_idx`<L-1, `rx_idx` increments; if `rx_idx`=L-1, the buffer empties.
- **RX ready.** `rx_lanes_ready` = `rx_enable && (!full || (rx_idx==L-1 && rx_out_ready))`. This allows back-to-back words with no bubble.
- **RX disable.** `rx_enable`=0 empties the buffer and clears `rx_idx`, `rx_out_valid` and `rx_data_out`.
- **Reset values.** `rst` clears everything to 0, including `mode_q`, both counters and every output (`tx_in_ready` follows `tx_enable`).
- **Precedence.** `rst` > disable > normal operation. A reset or disable arriving mid-stripe or mid-word drops the partial data with no flush.

## Timing
- TX latency: the last byte of a stripe is accepted at edge n; `tx_lanes`/`tx_lanes_valid` update at edge n, visible in cycle n+1.
- TX throughput: one lane word every L accepted bytes. The strobe width is exactly 1 cycle.
- RX latency: a word captured at edge n gives byte 0 valid in cycle n+1.
- RX throughput: L bytes in L cycles with `rx_out_ready` held high. A new word captured on the last-byte edge is presented on the next cycle with no gap.
- Stall: `rx_out_ready`=0 holds `rx_data_out`, `rx_idx` and `rx_out_valid` stable; `rx_lanes_ready`=0 while the buffer is full.
- L=1 (mode 1, or NUM_LANES=1): every TX accept strobes; every RX word yields one byte.
- TX and RX are independent except for the shared `mode_q`.

## Structure
- Package `usb4_lane_pkg`:
  - `LANE_IDX_W` = max(1, $clog2(NUM_LANES)) function/constant.
  - Mode encoding constants `MODE_ALL_LANES`=0 and `MODE_SINGLE_LANE`=1.
- Sub-module `lane_word_serializer` (RX buffer, `rx_idx`, ready/valid logic). The TX striping logic stays in the top level.

## Test plan
- **TX 2-lane:** NUM_LANES=2, mode 0, bytes 0xA1, 0xB2, 0xC3, 0xD4 back-to-back → `tx_lanes`=0xB2A1 with strobe, then 0xD4C3 with strobe 2 cycles later.
- **TX single-lane:** mode 1 loaded while both enables are low; bytes 0x11, 0x22 → two strobes, `tx_lanes`=0x0011 then 0x0022, upper lane 0.
- **TX partial drop:** accept 0x55, deassert `tx_enable` for 1 cycle, re-enable, send 0x66, 0x77 → one strobe with 0x7766; 0x55 is never output.
- **RX back-to-back:** words 0x3412 and 0x7856 offered continuously with `rx_out_ready`=1 → `rx_data_out` 0x12, 0x34, 0x56, 0x78 on 4 consecutive cycles; `rx_lanes_ready` high on both capture edges.
- **RX backpressure:** `rx_out_ready`=0 for 3 cycles while 0x34 is presented → 0x34 holds, `rx_lanes_ready`=0, and no byte is lost or duplicated.
- **Mode gating and reset:** toggle `lane_mode` while `tx_enable`=1 → `mode_q` is unchanged; assert `rst` mid-word → all outputs 0 at the next edge and `mode_q`=0.
